// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - requester/response bundle between ALU lanes and the fp_mul arbiter
interface fp_mul_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [NREQ-1:0]       resp_valid;
  logic [23:0]           resp_result;
  logic [TAG_W-1:0]      resp_tag;

  modport master (
    output req_valid, req_a, req_b, req_tag,
    input  req_ready, resp_valid, resp_result, resp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag,
    output req_ready, resp_valid, resp_result, resp_tag
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin sharing of one pipelined fp multiplier, optional FP_MUL_ARB_STATS_EN issue counters
module fp_mul_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 24,
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_mul_arbiter_if.slave       bus,
  input  logic                  drain_i,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [23:0]           mul_result,
  output logic                  busy,
  output logic [NREQ*16-1:0]    stat_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [NREQ-1:0]  grant;
  logic             grant_any;
  logic [PW-1:0]    grant_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [TAG_W-1:0] sel_tag;

  // Pipe stage 0 is written on the accept edge; stage LAT lines up with mul_result.
  logic [LAT:0]     pipe_v;
  logic [PW-1:0]    pipe_id  [LAT+1];
  logic [TAG_W-1:0] pipe_tag [LAT+1];

  // Round-robin search from rr_ptr; first valid requester wins unless draining.
  always_comb begin
    int j;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_tag   = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!grant_any && !drain_i && bus.req_valid[j]) begin
        grant[j]  = 1'b1;
        grant_any = 1'b1;
        grant_idx = PW'(j);
        sel_a     = bus.req_a[j*WIDTH +: WIDTH];
        sel_b     = bus.req_b[j*WIDTH +: WIDTH];
        sel_tag   = bus.req_tag[j*TAG_W +: TAG_W];
      end
    end
  end

  assign bus.req_ready = grant;

  // Capture operands of the accepted op and advance the pointer past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
    end else if (grant_any) begin
      mul_a  <= sel_a;
      mul_b  <= sel_b;
      rr_ptr <= (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tag pipe shifts every cycle; a bubble is pushed when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int k = 0; k <= LAT; k++) begin
        pipe_id[k]  <= '0;
        pipe_tag[k] <= '0;
      end
    end else begin
      pipe_v[0]   <= grant_any;
      pipe_id[0]  <= grant_idx;
      pipe_tag[0] <= sel_tag;
      for (int k = 1; k <= LAT; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_id[k]  <= pipe_id[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  // Output stage steers the result strobe back to the issuing requester.
  always_comb begin
    bus.resp_valid = '0;
    if (pipe_v[LAT]) begin
      bus.resp_valid[pipe_id[LAT]] = 1'b1;
    end
  end

  assign bus.resp_result = mul_result;
  assign bus.resp_tag    = pipe_tag[LAT];
  assign busy            = |pipe_v;

`ifdef FP_MUL_ARB_STATS_EN
  logic [15:0] stat_cnt [NREQ];

  // Count accepts per requester, sticking at all-ones until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        stat_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (grant[k] && stat_cnt[k] != 16'hFFFF) begin
          stat_cnt[k] <= stat_cnt[k] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_count[g*16 +: 16] = stat_cnt[g];
  end
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - directed self-checking bench for fp_mul_arbiter
module tb_fp_mul_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 24;
  localparam int LAT   = 2;
  localparam int TAG_W = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 drain_i;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [23:0]          mul_result;
  logic                 busy;
  logic [NREQ*16-1:0]   stat_count;
  logic [23:0]          mstage1;
  logic [23:0]          mstage2;

  int errors;
  int checks;

  fp_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  fp_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .drain_i    (drain_i),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .busy       (busy),
    .stat_count (stat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating 1/8/15 multiply, no special cases.
  function automatic logic [23:0] fpmul(input logic [23:0] a, input logic [23:0] b);
    logic [31:0] p;
    logic [9:0]  e;
    logic [14:0] m;
    p = {1'b1, a[14:0]} * {1'b1, b[14:0]};
    e = {2'b0, a[22:15]} + {2'b0, b[22:15]} - 10'd127;
    if (p[31]) begin
      m = p[30:16];
      e = e + 10'd1;
    end else begin
      m = p[29:15];
    end
    return {a[23] ^ b[23], e[7:0], m};
  endfunction

  // Multiplier model: LAT register stages after operands appear.
  always @(posedge clk) begin
    mstage1 <= fpmul(mul_a, mul_b);
    mstage2 <= mstage1;
  end
  assign mul_result = mstage2;

  task automatic set_req(input int i, input logic [23:0] a, input logic [23:0] b, input logic [3:0] tag);
    bus.req_a[i*WIDTH +: WIDTH]   = a;
    bus.req_b[i*WIDTH +: WIDTH]   = b;
    bus.req_tag[i*TAG_W +: TAG_W] = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.req_valid = '0;
    drain_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drain_i = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_tag = '0;
    repeat (2) tick();
    checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0000", bus.resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mul_a !== 24'h0 || mul_b !== 24'h0) begin errors++; $display("FAIL reset_mul_ops got=%h/%h exp=0/0", mul_a, mul_b); end
    checks++; if (stat_count !== '0) begin errors++; $display("FAIL reset_stat got=%h exp=0", stat_count); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_op();
    set_req(0, 24'h400000, 24'h404000, 4'd5);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    checks++; if (mul_a !== 24'h400000 || mul_b !== 24'h404000) begin errors++; $display("FAIL single_mul_ops got=%h/%h exp=400000/404000", mul_a, mul_b); end
    checks++; if (busy !== 1'b1 || bus.resp_valid !== 4'b0) begin errors++; $display("FAIL single_e0 busy=%b resp=%b exp busy=1 resp=0000", busy, bus.resp_valid); end
    tick();
    checks++; if (busy !== 1'b1 || bus.resp_valid !== 4'b0) begin errors++; $display("FAIL single_e1 busy=%b resp=%b exp busy=1 resp=0000", busy, bus.resp_valid); end
    tick();
    checks++; if (bus.resp_valid !== 4'b0001) begin errors++; $display("FAIL single_resp_valid got=%b exp=0001", bus.resp_valid); end
    checks++; if (bus.resp_result !== 24'h40C000) begin errors++; $display("FAIL single_result got=%h exp=40c000", bus.resp_result); end
    checks++; if (bus.resp_tag !== 4'd5) begin errors++; $display("FAIL single_tag got=%0d exp=5", bus.resp_tag); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_resp got=%b exp=1", busy); end
    tick();
    checks++; if (busy !== 1'b0 || bus.resp_valid !== 4'b0) begin errors++; $display("FAIL single_done busy=%b resp=%b exp busy=0 resp=0000", busy, bus.resp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 24'h400000, 24'h404000, 4'(i + 8));
    bus.req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 8 + LAT + 1; n++) begin
      if (n < 8) begin
        exp_v = 4'b0001 << (n % 4);
        checks++; if (bus.req_ready !== exp_v) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", n, bus.req_ready, exp_v); end
      end
      tick();
      if (n == 7) bus.req_valid = '0;
      if (n >= LAT && n - LAT < 8) begin
        exp_v = 4'b0001 << ((n - LAT) % 4);
        checks++; if (bus.resp_valid !== exp_v || bus.resp_tag !== 4'(((n - LAT) % 4) + 8)) begin
          errors++; $display("FAIL rr_resp[%0d] got=%b/%0d exp=%b/%0d", n, bus.resp_valid, bus.resp_tag, exp_v, ((n - LAT) % 4) + 8);
        end
      end else begin
        checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL rr_idle[%0d] got=%b exp=0000", n, bus.resp_valid); end
      end
      #1;
    end
  endtask

  task automatic test_wrap_skip();
    apply_reset();
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant1 got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0101;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_2_before_0 got=%b exp=0100", bus.req_ready); end
    tick();
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_then_0 got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_drain();
    logic exp_busy;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 24'h400000, 24'h404000, 4'(i + 1));
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      #1;
      if (n < 3) begin
        checks++; if (bus.req_ready !== (4'b0001 << n)) begin errors++; $display("FAIL drain_pre_grant[%0d] got=%b exp=%b", n, bus.req_ready, 4'b0001 << n); end
      end else begin
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL drain_blocked[%0d] got=%b exp=0000", n, bus.req_ready); end
      end
      tick();
      if (n == 2) drain_i = 1'b1;
      if (n >= LAT && n - LAT < 3) begin
        checks++; if (bus.resp_valid !== (4'b0001 << (n - LAT)) || bus.resp_tag !== 4'(n - LAT + 1)) begin
          errors++; $display("FAIL drain_resp[%0d] got=%b/%0d exp=%b/%0d", n, bus.resp_valid, bus.resp_tag, 4'b0001 << (n - LAT), n - LAT + 1);
        end
      end
      exp_busy = (n < 2 + LAT + 1);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL drain_busy[%0d] got=%b exp=%b", n, busy, exp_busy); end
    end
    drain_i = 1'b0;
    bus.req_valid = '0;
    #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(0, 24'h400000, 24'h404000, 4'd3);
    set_req(1, 24'h404000, 24'h404000, 4'd4);
    bus.req_valid = 4'b0011;
    tick();
    tick();
    bus.req_valid = '0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 4'b0 || busy !== 1'b0 || mul_a !== 24'h0) begin
      errors++; $display("FAIL mid_reset_clear resp=%b busy=%b mul_a=%h exp 0000/0/0", bus.resp_valid, busy, mul_a);
    end
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < LAT + 1; n++) begin
      checks++; if (bus.resp_valid !== 4'b0) begin errors++; $display("FAIL mid_no_stale[%0d] got=%b exp=0000", n, bus.resp_valid); end
      tick();
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
    #1;
  endtask

  task automatic test_stats();
    apply_reset();
`ifdef FP_MUL_ARB_STATS_EN
    bus.req_valid = 4'b0100;
    repeat (32'h10001) @(posedge clk);
    #1;
    bus.req_valid = '0;
    checks++; if (stat_count[2*16 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL stats_req2 got=%h exp=ffff", stat_count[2*16 +: 16]); end
    checks++; if (stat_count[0 +: 16] !== 16'h0 || stat_count[16 +: 16] !== 16'h0 || stat_count[48 +: 16] !== 16'h0) begin
      errors++; $display("FAIL stats_others got=%h exp=0 in slots 0,1,3", stat_count);
    end
`else
    bus.req_valid = 4'b0100;
    repeat (5) tick();
    bus.req_valid = '0;
    checks++; if (stat_count !== '0) begin errors++; $display("FAIL stats_tied_off got=%h exp=0", stat_count); end
`endif
    repeat (LAT + 1) tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_wrap_skip();
    test_drain();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one pipelined 24-bit FP multiplier (1 sign / 8 exp / 15 mantissa, fixed latency, no stall) between NREQ requesters.
- Round-robin arbitration issues at most one operation per cycle into the multiplier.
- A per-op ID/tag travels in a shift register matched to the multiplier latency, so each result returns to the requester that issued it.
- Sits between shader-core ALU lanes and the fp_mul datapath.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 24, operand width
- LAT, 2, multiplier latency in cycles from operand-present to result-valid
- TAG_W, 4, requester-supplied tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant/accept (one-hot or zero)
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_tag  in  NREQ*TAG_W  tag, same packing
- drain_i  in  1  when high, block new grants
- mul_a  out  WIDTH  registered operand A to multiplier
- mul_b  out  WIDTH  registered operand B to multiplier
- mul_result  in  24  multiplier result
- resp_valid  out  NREQ  one-hot result strobe, no backpressure
- resp_result  out  24  result, combinational pass-through of mul_result
- resp_tag  out  TAG_W  tag of the returning op
- busy  out  1  any op in flight
- stat_count  out  NREQ*16  issue counters (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert by integrator): rr_ptr=0, mul_a=mul_b=0, all pipe valids 0, resp_valid=0, busy=0, stat_count=0.
- Grant (combinational):
  - Search starts at rr_ptr, wraps mod NREQ; first i with req_valid[i] gets req_ready[i]=1.
  - All req_ready are 0 if drain_i=1 or no valid.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Accept: req_valid[i]&req_ready[i] at an edge.
  - That edge registers mul_a/mul_b from requester i.
  - Pushes {valid=1, id=i, tag} into the pipe.
  - Sets rr_ptr=(i+1) mod NREQ; wraps NREQ-1 to 0.
- No accept: mul_a/mul_b hold, push valid=0, rr_ptr unchanged.
- Pipe: depth LAT+1, shifts every cycle unconditionally.
  - Output stage drives resp_valid[id]=1 and resp_tag in exactly the cycle mul_result holds the op's product.
  - That cycle is LAT+1 cycles after the accept edge.
  - Back-to-back accepts yield back-to-back responses in issue order.
- resp_valid is 0 for all bits when the output stage is invalid; resp_result is don't-care then.
- busy = OR of all pipe valid bits.
- drain_i: in-flight ops complete normally. busy falls LAT+1 cycles after the last accept.
- Reset mid-operation: pipe cleared immediately; in-flight results are dropped and never signalled.
- Single requester holding req_valid continuously is granted every cycle. Starvation-free: any asserted requester is granted within NREQ cycles while drain_i=0.

Optional Feature:
- Macro: FP_MUL_ARB_STATS_EN.
- Defined: per-requester 16-bit counters at stat_count[i*16 +: 16].
  - Increment on each accept by requester i.
  - Saturate at 0xFFFF; cleared only by reset.
- Undefined: no counter flops; stat_count tied to 0.

Test Plan:
- Single op: req 0 valid, a=0x400000 (2.0), b=0x404000 (3.0), tag=5. Expect ready[0] same cycle; mul_a/mul_b after 1 edge; resp_valid=0001, result=0x40C000 (6.0), tag=5, LAT+1 cycles after accept; busy high throughout.
- Round robin: all 4 valid continuously for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3; resp_valid order identical, one per cycle, tags preserved.
- Wrap/skip: rr_ptr=3, only req 1 valid. Expect grant 1, next rr_ptr=2; then req 0 and 2 valid give grant 2 before 0.
- Drain: 3 ops in flight, assert drain_i with all valid. Expect no req_ready; 3 responses still delivered; busy=0 LAT+1 cycles after last accept.
- Reset mid-flight: accept 2 ops, pull rst_n low before the responses appear. Expect immediate resp_valid=0, busy=0, mul_a=0; after release, first grant goes to req 0.
- Stats (macro on): req 2 issues 0x10001 times. Expect stat_count[2] = 0xFFFF; other counters 0.
